// File: rtl/sample_stream_decoder_if.sv
// Handshake bundle for sample_stream_decoder: byte stream in, 14-bit sample stream out.
interface sample_stream_decoder_if;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic [13:0] sample_o;
  logic        sample_valid_o;
  logic        sample_ready_i;

  modport master (
    output byte_i, byte_valid_i, sample_ready_i,
    input  byte_ready_o, sample_o, sample_valid_o
  );

  modport slave (
    input  byte_i, byte_valid_i, sample_ready_i,
    output byte_ready_o, sample_o, sample_valid_o
  );
endinterface

// File: rtl/sample_stream_decoder.sv
// Reassembles header/low byte pairs into 14-bit samples, queues them in a
// first-word fall-through FIFO and counts framing errors.
module sample_stream_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  sample_stream_decoder_if.slave      bus,
  input  logic                        flush_i,
  output logic                        err_o,
  output logic [ERR_CNT_W-1:0]        err_count_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    HUNT = 1'b0,
    LOW  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [6:0]           hi_q, hi_d;
  logic [13:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic [13:0] push_data;

  // Ready depends only on registered state, so there is no path from sample_ready_i.
  assign fifo_full        = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty       = (level_q == '0);
  assign bus.byte_ready_o = (state_q == HUNT) || !fifo_full;
  assign accept           = bus.byte_valid_i && bus.byte_ready_o;
  assign pop              = !fifo_empty && bus.sample_ready_i && !flush_i;
  assign push_data        = {hi_q, bus.byte_i[6:0]};

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    push    = 1'b0;
    err_d   = 1'b0;
    if (flush_i) begin
      state_d = HUNT;
    end else if (accept) begin
      case (state_q)
        HUNT: begin
          if (bus.byte_i[7]) begin
            hi_d    = bus.byte_i[6:0];
            state_d = LOW;
          end else begin
            err_d = 1'b1;
          end
        end
        LOW: begin
          if (!bus.byte_i[7]) begin
            push    = 1'b1;
            state_d = HUNT;
          end else begin
            // A second header resyncs onto the newest one.
            err_d = 1'b1;
            hi_d  = bus.byte_i[6:0];
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= HUNT;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally; the level separates full from empty.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= err_d;
      if (err_d && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign bus.sample_valid_o = !fifo_empty;
  assign bus.sample_o       = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign err_o              = err_q;
  assign err_count_o        = err_cnt_q;
  assign fifo_level_o       = level_q;

endmodule

// File: tb/tb_sample_stream_decoder.sv
// Bench for sample_stream_decoder: vector table, sample scoreboard and
// hand-written backpressure, reset, flush and saturation sequences.
module tb_sample_stream_decoder;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        flush_i;
  logic        err_o;
  logic [15:0] err_count_o;
  logic [2:0]  fifo_level_o;
  logic        err4_o;
  logic [3:0]  err4_count_o;
  logic [2:0]  level4_o;

  int vec_count  = 0;
  int miscompares = 0;

  logic [13:0] exp_q[$];

  sample_stream_decoder_if bus ();
  sample_stream_decoder_if bus4 ();

  always #5 clk_i = ~clk_i;

  sample_stream_decoder #(.FIFO_DEPTH(4), .ERR_CNT_W(16)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .bus         (bus),
    .flush_i     (flush_i),
    .err_o       (err_o),
    .err_count_o (err_count_o),
    .fifo_level_o(fifo_level_o)
  );

  sample_stream_decoder #(.FIFO_DEPTH(4), .ERR_CNT_W(4)) dut4 (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .bus         (bus4),
    .flush_i     (1'b0),
    .err_o       (err4_o),
    .err_count_o (err4_count_o),
    .fifo_level_o(level4_o)
  );

  typedef struct {
    logic [7:0]  b;
    logic        v;
    logic        push;
    logic [13:0] sample;
    logic [2:0]  level;
    logic        valid;
    logic        err;
    logic [15:0] cnt;
    logic        bready;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [7:0] b, input logic v, input logic push,
                              input logic [13:0] sample, input logic [2:0] level,
                              input logic valid, input logic err, input logic [15:0] cnt,
                              input logic bready);
    vec_t r;
    r.b = b; r.v = v; r.push = push; r.sample = sample; r.level = level;
    r.valid = valid; r.err = err; r.cnt = cnt; r.bready = bready;
    return r;
  endfunction

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.byte_i       = v.b;
    bus.byte_valid_i = v.v;
    if (v.push) exp_q.push_back(v.sample);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    compare($sformatf("vec%0d_level", idx),  32'(fifo_level_o),       32'(v.level));
    compare($sformatf("vec%0d_valid", idx),  32'(bus.sample_valid_o), 32'(v.valid));
    compare($sformatf("vec%0d_err", idx),    32'(err_o),              32'(v.err));
    compare($sformatf("vec%0d_cnt", idx),    32'(err_count_o),        32'(v.cnt));
    compare($sformatf("vec%0d_bready", idx), 32'(bus.byte_ready_o),   32'(v.bready));
  endtask

  // Drives one byte from just after a rising edge and holds it until accepted.
  task automatic send_byte(input logic [7:0] b, input logic exp_push, input logic [13:0] s);
    int waited = 0;
    bus.byte_i       = b;
    bus.byte_valid_i = 1'b1;
    if (exp_push) exp_q.push_back(s);
    @(negedge clk_i);
    while (!bus.byte_ready_o && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    if (!bus.byte_ready_o) begin
      vec_count++;
      miscompares++;
      $display("[TB] FAIL send_timeout: byte 0x%0h not accepted, byte_ready_o=%0b want 1", b, bus.byte_ready_o);
    end
    @(posedge clk_i);
    #1;
    bus.byte_valid_i = 1'b0;
  endtask

  // Scoreboard: every pop the DUT is about to perform is checked against the queue head.
  always @(negedge clk_i) begin
    if (reset_ni && bus.sample_valid_o && bus.sample_ready_i) begin
      if (exp_q.size() == 0) begin
        vec_count++;
        miscompares++;
        $display("[TB] FAIL unexpected_sample: got 0x%0h, want no sample", bus.sample_o);
      end else begin
        compare("sample_order", 32'(bus.sample_o), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = mk(8'h9F, 1'b1, 1'b0, 14'h0000, 3'd0, 1'b0, 1'b0, 16'd0, 1'b1);
    vecs[1]  = mk(8'h55, 1'b1, 1'b1, 14'h0FD5, 3'd1, 1'b1, 1'b0, 16'd0, 1'b1);
    vecs[2]  = mk(8'h12, 1'b1, 1'b0, 14'h0000, 3'd0, 1'b0, 1'b1, 16'd1, 1'b1);
    vecs[3]  = mk(8'h00, 1'b0, 1'b0, 14'h0000, 3'd0, 1'b0, 1'b0, 16'd1, 1'b1);
    vecs[4]  = mk(8'h81, 1'b1, 1'b0, 14'h0000, 3'd0, 1'b0, 1'b0, 16'd1, 1'b1);
    vecs[5]  = mk(8'h83, 1'b1, 1'b0, 14'h0000, 3'd0, 1'b0, 1'b1, 16'd2, 1'b1);
    vecs[6]  = mk(8'h04, 1'b1, 1'b1, 14'h0184, 3'd1, 1'b1, 1'b0, 16'd2, 1'b1);
    vecs[7]  = mk(8'h00, 1'b0, 1'b0, 14'h0000, 3'd0, 1'b0, 1'b0, 16'd2, 1'b1);
    vecs[8]  = mk(8'h12, 1'b0, 1'b0, 14'h0000, 3'd0, 1'b0, 1'b0, 16'd2, 1'b1);
    vecs[9]  = mk(8'hC0, 1'b1, 1'b0, 14'h0000, 3'd0, 1'b0, 1'b0, 16'd2, 1'b1);
    vecs[10] = mk(8'h7F, 1'b1, 1'b1, 14'h207F, 3'd1, 1'b1, 1'b0, 16'd2, 1'b1);
    vecs[11] = mk(8'h00, 1'b0, 1'b0, 14'h0000, 3'd0, 1'b0, 1'b0, 16'd2, 1'b1);

    reset_ni            = 1'b0;
    flush_i             = 1'b0;
    bus.byte_i          = 8'h00;
    bus.byte_valid_i    = 1'b0;
    bus.sample_ready_i  = 1'b0;
    bus4.byte_i         = 8'h00;
    bus4.byte_valid_i   = 1'b0;
    bus4.sample_ready_i = 1'b1;

    #12;
    compare("rst_level",      32'(fifo_level_o),       32'd0);
    compare("rst_valid",      32'(bus.sample_valid_o), 32'd0);
    compare("rst_sample",     32'(bus.sample_o),       32'd0);
    compare("rst_err",        32'(err_o),              32'd0);
    compare("rst_cnt",        32'(err_count_o),        32'd0);
    compare("rst_bready",     32'(bus.byte_ready_o),   32'd1);
    compare("rst_cnt_narrow", 32'(err4_count_o),       32'd0);

    @(posedge clk_i);
    #1;
    reset_ni           = 1'b1;
    bus.sample_ready_i = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk_i);
      #1;
      checkOutput(vecs[i], i);
    end

    // Backpressure: fill the FIFO, stall a fifth sample, release one slot.
    bus.sample_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send_byte(8'(8'h80 + k + 1), 1'b0, 14'h0000);
      send_byte(8'(8'h10 + k), 1'b1, {7'(k + 1), 7'(16 + k)});
    end
    send_byte(8'h85, 1'b0, 14'h0000);
    compare("bp_full_level",  32'(fifo_level_o),     32'd4);
    compare("bp_full_bready", 32'(bus.byte_ready_o), 32'd0);
    bus.byte_i       = 8'h14;
    bus.byte_valid_i = 1'b1;
    exp_q.push_back({7'd5, 7'h14});
    repeat (3) @(posedge clk_i);
    #1;
    compare("bp_hold_level", 32'(fifo_level_o), 32'd4);
    bus.sample_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.sample_ready_i = 1'b0;
    compare("bp_pop_level",  32'(fifo_level_o),     32'd3);
    compare("bp_pop_bready", 32'(bus.byte_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    bus.byte_valid_i = 1'b0;
    compare("bp_refill_level", 32'(fifo_level_o), 32'd4);
    bus.sample_ready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (exp_q.size() == 0 && fifo_level_o == 3'd0) break;
      @(posedge clk_i);
      #1;
    end
    compare("bp_drain_level", 32'(fifo_level_o), 32'd0);
    compare("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a frame drops the held header.
    send_byte(8'hFF, 1'b0, 14'h0000);
    reset_ni = 1'b0;
    #3;
    compare("midrst_bready", 32'(bus.byte_ready_o), 32'd1);
    compare("midrst_sample", 32'(bus.sample_o),     32'd0);
    compare("midrst_cnt",    32'(err_count_o),      32'd0);
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    send_byte(8'h01, 1'b0, 14'h0000);
    compare("midrst_err",   32'(err_o),        32'd1);
    compare("midrst_cnt1",  32'(err_count_o),  32'd1);
    compare("midrst_level", 32'(fifo_level_o), 32'd0);
    @(posedge clk_i);
    #1;
    compare("midrst_err_once", 32'(err_o),        32'd0);
    compare("midrst_no_sample", 32'(fifo_level_o), 32'd0);

    // Flush with three samples queued and a header offered in the same cycle.
    bus.sample_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send_byte(8'(8'hA0 + k), 1'b0, 14'h0000);
      send_byte(8'(8'h20 + k), 1'b1, {7'(32 + k), 7'(32 + k)});
    end
    compare("flush_pre_level", 32'(fifo_level_o), 32'd3);
    flush_i          = 1'b1;
    bus.byte_i       = 8'h90;
    bus.byte_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i          = 1'b0;
    bus.byte_valid_i = 1'b0;
    exp_q.delete();
    compare("flush_level", 32'(fifo_level_o),       32'd0);
    compare("flush_valid", 32'(bus.sample_valid_o), 32'd0);
    compare("flush_err",   32'(err_o),              32'd0);
    compare("flush_cnt",   32'(err_count_o),        32'd1);
    send_byte(8'h05, 1'b0, 14'h0000);
    compare("flush_hunt_err",   32'(err_o),        32'd1);
    compare("flush_hunt_cnt",   32'(err_count_o),  32'd2);
    compare("flush_hunt_level", 32'(fifo_level_o), 32'd0);

    // Narrow counter saturates at all-ones.
    bus4.byte_i       = 8'h12;
    bus4.byte_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i);
      #1;
      compare($sformatf("sat_cnt%0d", i), 32'(err4_count_o), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    bus4.byte_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    compare("sat_hold",  32'(err4_count_o), 32'hF);
    compare("sat_level", 32'(level4_o),     32'd0);

    compare("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/sample_stream_decoder.md
SAMPLE_STREAM_DECODER -- requirements
Module: sample_stream_decoder

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of sample FIFO entries; must be a power of two and at least 2.
REQ-002 Parameter: ERR_CNT_W, default 16, width of the error counter.
REQ-003 Port: clk_i  input  1  system clock; all state changes on rising edge.
REQ-004 Port: reset_ni  input  1  asynchronous, active-low reset.
REQ-005 Port: byte_i  input  8  received byte from the host link.
REQ-006 Port: byte_valid_i  input  1  byte_i is valid this cycle.
REQ-007 Port: byte_ready_o  output  1  decoder accepts byte_i this cycle.
REQ-008 Port: flush_i  input  1  synchronous flush request.
REQ-009 Port: sample_o  output  14  sample at the FIFO head.
REQ-010 Port: sample_valid_o  output  1  sample_o is valid.
REQ-011 Port: sample_ready_i  input  1  consumer takes sample_o this cycle.
REQ-012 Port: err_o  output  1  one-cycle pulse per framing error.
REQ-013 Port: err_count_o  output  ERR_CNT_W  saturating framing-error count.
REQ-014 Port: fifo_level_o  output  clog2(FIFO_DEPTH)+1  number of stored samples.

Function
REQ-015 Framing: each sample is two bytes. The header byte has bit7=1 and carries sample[13:7] in bits[6:0]. The low byte has bit7=0 and carries sample[6:0] in bits[6:0].
REQ-016 A byte is accepted only in a cycle where byte_valid_i=1 and byte_ready_o=1; all other bytes are ignored with no state change.
REQ-017 FSM states: HUNT (waiting for a header) and LOW (header held, waiting for the low byte).
REQ-018 HUNT, accepted byte with bit7=1: latch bits[6:0] as hi and go to LOW.
REQ-019 HUNT, accepted byte with bit7=0: discard it, flag a framing error and stay in HUNT.
REQ-020 LOW, accepted byte with bit7=0: push {hi, byte[6:0]} into the FIFO and go to HUNT.
REQ-021 LOW, accepted byte with bit7=1: flag a framing error, replace hi with the new bits[6:0] (resync) and stay in LOW.
REQ-022 byte_ready_o = (state==HUNT) OR (FIFO not full); it is driven from registers only, with no combinational path from sample_ready_i.
REQ-023 The FIFO is first-word fall-through: sample_valid_o = (level != 0) and sample_o = head entry.
REQ-024 A pop occurs when sample_valid_o=1 and sample_ready_i=1.
REQ-025 Simultaneous push and pop leave the level unchanged and preserve order.
REQ-026 No push ever occurs while the FIFO is full.
REQ-027 Latency: a sample appears on sample_o/sample_valid_o on the cycle after its low byte is accepted, when the FIFO was empty.
REQ-028 Framing error: err_o=1 for exactly the cycle after the offending byte is accepted, and err_count_o increments by 1.
REQ-029 err_count_o saturates at all-ones and never wraps.
REQ-030 flush_i=1: next cycle the FIFO is empty and state is HUNT.
REQ-031 flush_i has priority over any byte accepted or pop in the same cycle.
REQ-032 flush_i leaves err_count_o unchanged and generates no error.
REQ-033 Read and write pointers wrap modulo FIFO_DEPTH; the level distinguishes full from empty.

Reset
REQ-034 reset_ni=0 asynchronously forces: state HUNT, FIFO empty (fifo_level_o=0), sample_valid_o=0, err_o=0, err_count_o=0, hi=0.
REQ-035 While reset is asserted, byte_ready_o=1 and sample_o=0.
REQ-036 Reset asserted mid-frame discards the held header. The next byte is decoded in HUNT.

Verification
REQ-037 Bytes 0x9F, 0x55 -> sample_o=0x0FD5 with sample_valid_o=1 one cycle after 0x55; err_count_o=0.
REQ-038 Byte 0x12 in HUNT -> err_o pulses once, err_count_o=1, fifo_level_o stays 0.
REQ-039 Bytes 0x81, 0x83, 0x04 -> one error, err_count_o=1, single sample 0x0184.
REQ-040 sample_ready_i=0 and five samples sent -> fifo_level_o=4, byte_ready_o=0 after fifth header. Then one pop -> fifth sample accepted, output order matches input order.
REQ-041 Reset pulse after header 0xFF, then 0x01 -> err_count_o=1, no sample. Flush with 3 samples queued and a byte in the same cycle -> level 0, state HUNT, byte dropped.
REQ-042 ERR_CNT_W=4 and 20 stray low bytes -> err_count_o holds 0xF.
